// File: rtl/frame_buf_sched_pkg.sv
// Shared definitions for the frame-buffer scheduler.
//   BUF_NUM   : number of frame buffers (fixed at 4)
//   IDX_W     : width of a buffer index
//   buf_idx_t : buffer index type
//   buf_mask_t: one bit per buffer, set = buffer excluded from writer pick
package frame_buf_sched_pkg;

    localparam int unsigned BUF_NUM = 4;
    localparam int unsigned IDX_W   = 2;

    typedef logic [IDX_W-1:0]   buf_idx_t;
    typedef logic [BUF_NUM-1:0] buf_mask_t;

endpackage : frame_buf_sched_pkg

// File: rtl/frame_buf_sched_free_buf_pick.sv
// Combinational free-buffer picker.
// Ports:
//   excl_mask : in  4  bit i set = buffer i is excluded
//   free_idx  : out 2  lowest index with a clear mask bit; 0 if mask is full
//                      (cannot happen: at most 3 buffers are ever excluded)
module free_buf_pick
    import frame_buf_sched_pkg::*;
(
    input  logic [BUF_NUM-1:0] excl_mask,
    output logic [IDX_W-1:0]   free_idx
);

    logic found;

    always_comb begin
        free_idx = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < BUF_NUM; i++) begin
            if (!found && !excl_mask[i]) begin
                free_idx = buf_idx_t'(i);
                found    = 1'b1;
            end
        end
    end

endmodule : free_buf_pick

// File: rtl/frame_buf_sched.sv
// Frame-buffer scheduler: one writer, two readers, four DDR frame buffers.
// The writer is never given a buffer that is the latest complete frame or
// that either reader currently holds, so readers never see tearing.
// Ports:
//   clk                 : in  1    clock
//   resetn              : in  1    async active-low reset
//   buf0_addr..buf3_addr: in  AW   buffer base addresses (quasi-static)
//   w_sof               : in  1    writer start-of-frame pulse
//   w_addr / w_idx      : out AW/2 writer buffer
//   r0_sof              : in  1    reader 0 start-of-frame pulse
//   r0_addr / r0_idx    : out AW/2 reader 0 buffer
//   r1_sof              : in  1    reader 1 start-of-frame pulse
//   r1_addr / r1_idx    : out AW/2 reader 1 buffer
//   latest_valid        : out 1    at least one frame has completed
//   latest_idx          : out 2    latest completed buffer
module frame_buf_sched
    import frame_buf_sched_pkg::*;
#(
    parameter int unsigned C_ADDR_WIDTH = 32,
    parameter int unsigned C_BUF_NUM    = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [C_ADDR_WIDTH-1:0] buf0_addr,
    input  logic [C_ADDR_WIDTH-1:0] buf1_addr,
    input  logic [C_ADDR_WIDTH-1:0] buf2_addr,
    input  logic [C_ADDR_WIDTH-1:0] buf3_addr,
    input  logic                    w_sof,
    output logic [C_ADDR_WIDTH-1:0] w_addr,
    output logic [1:0]              w_idx,
    input  logic                    r0_sof,
    output logic [C_ADDR_WIDTH-1:0] r0_addr,
    output logic [1:0]              r0_idx,
    input  logic                    r1_sof,
    output logic [C_ADDR_WIDTH-1:0] r1_addr,
    output logic [1:0]              r1_idx,
    output logic                    latest_valid,
    output logic [1:0]              latest_idx
);

    logic                    w_active;
    logic                    r0_valid;
    logic                    r1_valid;

    logic                    latest_valid_n;
    buf_idx_t                latest_idx_n;
    logic                    r0_valid_n;
    buf_idx_t                r0_idx_n;
    logic                    r1_valid_n;
    buf_idx_t                r1_idx_n;
    logic                    w_active_n;
    buf_idx_t                w_idx_n;

    logic [C_BUF_NUM-1:0]    excl_mask;
    buf_idx_t                pick_idx;

    logic [C_ADDR_WIDTH-1:0] addr_tbl [C_BUF_NUM];

    // Next-state is evaluated in three chained stages (retire, readers,
    // writer) so that a reader and the writer pulsing in the same cycle both
    // see the frame that is being retired on that very edge.
    always_comb begin
        // retire the finishing frame
        latest_valid_n = latest_valid;
        latest_idx_n   = latest_idx;
        if (w_sof && w_active) begin
            latest_valid_n = 1'b1;
            latest_idx_n   = w_idx;
        end

        // readers latch the latest complete frame; with none yet they hold
        r0_valid_n = r0_valid;
        r0_idx_n   = r0_idx;
        if (r0_sof && latest_valid_n) begin
            r0_valid_n = 1'b1;
            r0_idx_n   = latest_idx_n;
        end

        r1_valid_n = r1_valid;
        r1_idx_n   = r1_idx;
        if (r1_sof && latest_valid_n) begin
            r1_valid_n = 1'b1;
            r1_idx_n   = latest_idx_n;
        end

        // everything the writer must avoid after this edge
        excl_mask = '0;
        if (latest_valid_n) excl_mask[latest_idx_n] = 1'b1;
        if (r0_valid_n)     excl_mask[r0_idx_n]     = 1'b1;
        if (r1_valid_n)     excl_mask[r1_idx_n]     = 1'b1;

        w_active_n = w_active;
        w_idx_n    = w_idx;
        if (w_sof) begin
            w_active_n = 1'b1;
            w_idx_n    = pick_idx;
        end
    end

    free_buf_pick u_free_buf_pick (
        .excl_mask (excl_mask),
        .free_idx  (pick_idx)
    );

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            w_active     <= 1'b0;
            w_idx        <= '0;
            latest_valid <= 1'b0;
            latest_idx   <= '0;
            r0_valid     <= 1'b0;
            r0_idx       <= '0;
            r1_valid     <= 1'b0;
            r1_idx       <= '0;
        end else begin
            w_active     <= w_active_n;
            w_idx        <= w_idx_n;
            latest_valid <= latest_valid_n;
            latest_idx   <= latest_idx_n;
            r0_valid     <= r0_valid_n;
            r0_idx       <= r0_idx_n;
            r1_valid     <= r1_valid_n;
            r1_idx       <= r1_idx_n;
        end
    end

    // Addresses follow the index registers combinationally, so an async
    // reset returns every address to buf0_addr without a clock edge.
    always_comb begin
        addr_tbl[0] = buf0_addr;
        addr_tbl[1] = buf1_addr;
        addr_tbl[2] = buf2_addr;
        addr_tbl[3] = buf3_addr;
    end

    assign w_addr  = addr_tbl[w_idx];
    assign r0_addr = addr_tbl[r0_idx];
    assign r1_addr = addr_tbl[r1_idx];

endmodule : frame_buf_sched
